// File: rtl/pmem_responder.sv
// Line-granular main memory behind the cache: one 128-bit line per request, one-cycle pmem_resp.
// Optional PMEM_RANDOM_LATENCY_EN adds 0..3 LFSR-chosen extra busy cycles per request.
`timescale 1ns/1ps
module pmem_responder #(
  parameter int LATENCY        = 3,
  parameter int LINE_ADDR_BITS = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         pmem_busy,
  output logic [1:0]   dbg_state
);

  localparam int DEPTH = 2 ** LINE_ADDR_BITS;
  localparam int CNT_W = $clog2(LATENCY + 4) + 1;

  // Handshake: pmem_read/pmem_write are held by the requester until the
  // single-cycle pmem_resp; the request is sampled only in IDLE and its
  // op/index/wdata are latched there, so later input changes are ignored.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      wr_q, wr_d;
  logic [LINE_ADDR_BITS-1:0] idx_q, idx_d;
  logic [127:0]              wdata_q, wdata_d;
  logic [127:0]              rdata_q, rdata_d;
  logic [CNT_W-1:0]          accept_cnt;
  logic                      mem_we;
  logic [127:0]              mem [DEPTH];

  // Low nibble selects bytes within a line; only the line index is used.
  logic unused_addr;
  assign unused_addr = ^pmem_address;

`ifdef PMEM_RANDOM_LATENCY_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'hA5;
    else        lfsr_q <= lfsr_d;
  end

  assign accept_cnt = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);
`else
  assign accept_cnt = CNT_W'(LATENCY - 1);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pmem_read || pmem_write) begin
          // A simultaneous read is dropped: the write takes the slot.
          wr_d    = pmem_write;
          idx_d   = pmem_address[LINE_ADDR_BITS+3:4];
          wdata_d = pmem_wdata;
          cnt_d   = accept_cnt;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (wr_q) mem_we  = 1'b1;
          else      rdata_d = mem[idx_q];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is not reset; an aborted write never reaches mem_we because state resets.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

  assign pmem_rdata = rdata_q;
  assign pmem_resp  = (state_q == S_DONE);
  assign pmem_busy  = (state_q == S_BUSY) || (state_q == S_DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Directed + randomized bench for pmem_responder with a line model and read-data scoreboard.
`timescale 1ns/1ps
module tb_pmem_responder;
  localparam int LATENCY = 3;
  localparam int LAB     = 12;

  // clock / reset
  logic         clk = 1'b0;
  logic         rst_n;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp, pmem_busy;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  pmem_responder #(.LATENCY(LATENCY), .LINE_ADDR_BITS(LAB)) dut (
    .clk(clk), .rst_n(rst_n), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .pmem_busy(pmem_busy), .dbg_state(dbg_state)
  );

  // scoreboard
  logic [127:0] exp_q[$];
  logic [127:0] mem_model [int];
  logic [127:0] last_rd;
  int checks = 0;
  int errors = 0;
  int lat_seen [4];

  task automatic check(input logic [127:0] obs, input logic [127:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: issue one request, optionally perturb address/data during BUSY
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [127:0] wd, input logic alt_en,
                        input logic [15:0] alt_addr, input string tag);
    int idx;
    int lat;
    logic is_rd;
    idx   = int'(addr[LAB+3:4]);
    is_rd = rd & ~wr;
    if (wr) mem_model[idx] = wd;
    else    exp_q.push_back(mem_model[idx]);
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wd;
    lat = 0;
    while (pmem_resp !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && alt_en) begin
        pmem_address = alt_addr;
        pmem_wdata   = ~wd;
      end
    end
    check(128'(pmem_resp), 128'd1, {tag, "_resp_seen"});
`ifdef PMEM_RANDOM_LATENCY_EN
    check(128'(lat >= LATENCY + 1 && lat <= LATENCY + 4), 128'd1, {tag, "_lat_range"});
    if (lat >= LATENCY + 1 && lat <= LATENCY + 4) lat_seen[lat - LATENCY - 1]++;
`else
    check(128'(lat), 128'(LATENCY + 1), {tag, "_latency"});
`endif
    check(128'(pmem_busy), 128'd1, {tag, "_busy_done"});
    if (is_rd) begin
      last_rd = exp_q.pop_front();
      check(pmem_rdata, last_rd, {tag, "_rdata"});
    end else begin
      check(pmem_rdata, last_rd, {tag, "_rdata_hold"});
    end
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    @(negedge clk);
    check(128'(pmem_resp), 128'd0, {tag, "_resp_width"});
    check(128'(pmem_busy), 128'd0, {tag, "_idle_after"});
  endtask

  // driver: start a request and reset mid-BUSY
  task automatic abort_req(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [127:0] wd, input string tag);
    int resp_cnt;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wd;
    @(negedge clk);
    @(negedge clk);
    check(128'(pmem_busy), 128'd1, {tag, "_busy_before"});
    #2 rst_n = 1'b0;
    #1;
    check(128'(pmem_resp), 128'd0, {tag, "_rst_resp"});
    check(128'(pmem_busy), 128'd0, {tag, "_rst_busy"});
    check(pmem_rdata, 128'd0, {tag, "_rst_rdata"});
    last_rd    = '0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    resp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pmem_resp === 1'b1) resp_cnt++;
    end
    check(128'(resp_cnt), 128'd0, {tag, "_no_resp"});
  endtask

  initial begin
    logic [127:0] d;
    logic [15:0]  a;
    rst_n = 1'b0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = '0;
    pmem_wdata = '0;
    last_rd = '0;
    for (int i = 0; i < 4; i++) lat_seen[i] = 0;
    #12;
    check(128'(pmem_resp), 128'd0, "reset_resp");
    check(128'(pmem_busy), 128'd0, "reset_busy");
    check(pmem_rdata, 128'd0, "reset_rdata");
    check(128'(dbg_state), 128'd0, "reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // write then read of the same line via a different byte offset
    do_req(1'b0, 1'b1, 16'h0120, 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF, 1'b0, 16'h0, "wr_0120");
    do_req(1'b1, 1'b0, 16'h012E, 128'h0, 1'b0, 16'h0, "rd_012E");

    // async reset during BUSY of a read
    abort_req(1'b1, 1'b0, 16'h0120, 128'h0, "rst_rd");

    // read and write together: write wins, rdata untouched
    do_req(1'b1, 1'b0, 16'h0120, 128'h0, 1'b0, 16'h0, "rd_reload");
    do_req(1'b1, 1'b1, 16'h0040, 128'h4040_4040_1111_2222_3333_4444_5555_6666, 1'b0, 16'h0, "rdwr_0040");
    do_req(1'b1, 1'b0, 16'h0040, 128'h0, 1'b0, 16'h0, "rd_0040");

    // address and data changes after accept are ignored
    do_req(1'b0, 1'b1, 16'h0200, 128'h0200_0200_0200_0200_0200_0200_0200_0200, 1'b0, 16'h0, "wr_0200");
    do_req(1'b0, 1'b1, 16'h0300, 128'h0300_0300_0300_0300_0300_0300_0300_0300, 1'b0, 16'h0, "wr_0300");
    do_req(1'b1, 1'b0, 16'h0200, 128'h0, 1'b1, 16'h0300, "rd_0200_alt");
    do_req(1'b0, 1'b1, 16'h0300, 128'h3333_0000_3333_0000_3333_0000_3333_0000, 1'b1, 16'h0200, "wr_0300_alt");
    do_req(1'b1, 1'b0, 16'h0200, 128'h0, 1'b0, 16'h0, "rd_0200_chk");
    do_req(1'b1, 1'b0, 16'h0300, 128'h0, 1'b0, 16'h0, "rd_0300_chk");

    // reset during a write: old line must survive
    do_req(1'b0, 1'b1, 16'h0500, 128'h0500_01D0_0500_01D0_0500_01D0_0500_01D0, 1'b0, 16'h0, "wr_0500_old");
    abort_req(1'b0, 1'b1, 16'h0500, 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888, "rst_wr");
    do_req(1'b1, 1'b0, 16'h0500, 128'h0, 1'b0, 16'h0, "rd_0500_old");

    // randomized traffic over a few lines, including the top line index
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      a = {i[2:0] == 3'd7 ? 12'hFFF : {9'h0, i[2:0]}, 4'($urandom_range(0, 15))};
      do_req(1'b0, 1'b1, a, d, 1'b0, 16'h0, "rnd_init");
    end
    for (int i = 0; i < 30; i++) begin
      logic [2:0] k;
      k = 3'($urandom_range(0, 7));
      a = {k == 3'd7 ? 12'hFFF : {9'h0, k}, 4'($urandom_range(0, 15))};
      d = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 0) do_req(1'b0, 1'b1, a, d, 1'b0, 16'h0, "rnd_wr");
      else                           do_req(1'b1, 1'b0, a, d, 1'b0, 16'h0, "rnd_rd");
    end

`ifdef PMEM_RANDOM_LATENCY_EN
    for (int i = 0; i < 1000; i++) begin
      a = {9'h0, 3'($urandom_range(0, 6)), 4'h0};
      do_req(1'b1, 1'b0, a, 128'h0, 1'b0, 16'h0, "lfsr_rd");
    end
    for (int i = 0; i < 4; i++) check(128'(lat_seen[i] > 0), 128'd1, "lfsr_all_values");
`endif

    check(128'(exp_q.size()), 128'd0, "queue_empty");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
